// File: rtl/debounce_toggle.sv
// rtl/debounce_toggle.sv - button synchroniser and debounce FSM emitting one-cycle press pulses
// Optional auto-repeat while the button is held: define DEBOUNCE_AUTOREPEAT_EN.

module debounce_toggle #(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_CYCLES = 8,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  output logic               pulse,
  output logic               level,
  output logic [COUNT_W-1:0] press_count
);

  localparam int MAX_CYCLES = (STABLE_CYCLES > REPEAT_CYCLES) ? STABLE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s2_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               level_q, level_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               sample;

  assign sample = s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= btn;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (sample) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sample) begin
          state_d = IDLE;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
          count_d = count_q + 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sample) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
          if (cnt_q == REPEAT_LAST) begin
            pulse_d = 1'b1;
            count_d = count_q + 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      RELEASE_CHK: begin
        // A bounce back to 1 returns to HELD without a new pulse.
        if (sample) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pulse       = pulse_q;
  assign level       = level_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_debounce_toggle.sv
// tb/tb_debounce_toggle.sv - directed and random checks of debounce_toggle against a run-length model
// Auto-repeat expectations follow DEBOUNCE_AUTOREPEAT_EN.

module tb_debounce_toggle;

  localparam int STABLE = 4;
  localparam int REPEAT = 8;
  localparam int CW     = 8;

  logic          clk;
  logic          rst;
  logic          btn;
  logic          pulse;
  logic          level;
  logic [CW-1:0] press_count;

  debounce_toggle #(
    .STABLE_CYCLES(STABLE),
    .REPEAT_CYCLES(REPEAT),
    .COUNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .pulse(pulse),
    .level(level),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream T flip-flop driven by pulse
  logic tb_q;
  always @(posedge clk) begin
    if (rst) tb_q <= 1'b0;
    else if (pulse) tb_q <= ~tb_q;
  end

  int checks = 0;
  int errors = 0;

  logic          m_s1, m_s2, m_level, m_pulse, m_q;
  int            m_run, m_rep;
  logic [CW-1:0] m_count;
  logic          prev_pulse;
  int            npulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Level flips once the synchronised sample has disagreed with it for STABLE+1 edges in a row.
  task automatic model_edge(input logic r, input logic b);
    logic smp;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_q = 0;
      m_run = 0; m_rep = 0; m_count = '0;
    end else begin
      m_q     = m_q ^ m_pulse;
      smp     = m_s2;
      m_s2    = m_s1;
      m_s1    = b;
      m_pulse = 0;
      if (smp != m_level) begin
        m_run++;
        m_rep = 0;
        if (m_run == STABLE + 1) begin
          m_level = ~m_level;
          m_run   = 0;
          if (m_level) begin
            m_pulse = 1;
            m_count = m_count + 1'b1;
          end
        end
      end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
        if (m_level && m_run == 0) begin
          m_rep++;
          if (m_rep == REPEAT) begin
            m_pulse = 1;
            m_count = m_count + 1'b1;
            m_rep   = 0;
          end
        end
`endif
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    btn = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check("pulse", {31'd0, pulse}, {31'd0, m_pulse});
    check("level", {31'd0, level}, {31'd0, m_level});
    check("press_count", {24'd0, press_count}, {24'd0, m_count});
    check("t_ff_q", {31'd0, tb_q}, {31'd0, m_q});
    check("pulse_back_to_back", {31'd0, pulse & prev_pulse}, 32'd0);
    prev_pulse = r ? 1'b0 : pulse;
    if (pulse) npulses++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  int edge_at;
  int fall_at;
  int seen;
  int exp_rep;

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    prev_pulse = 1'b0;
    npulses = 0;

    // Button held through reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("rst_pulse", {31'd0, pulse}, 32'd0);
    check("rst_count", {24'd0, press_count}, 32'd0);
    edge_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if (pulse && edge_at == 0) edge_at = i;
    end
    check("rst_held_pulse_edge", edge_at, 7);
    check("rst_held_count", {24'd0, press_count}, 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // Clean press and release
    do_reset();
    npulses = 0;
    edge_at = 0;
    fall_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1);
      if (pulse && edge_at == 0) edge_at = i;
    end
    for (int i = 21; i <= 32; i++) begin
      step(1'b0, 1'b0);
      if (!level && fall_at == 0) fall_at = i;
    end
    check("clean_pulse_edge", edge_at, 7);
    check("clean_fall_edge", fall_at, 27);
    check("clean_pulses", npulses, 32'd1);
    check("clean_count", {24'd0, press_count}, 32'd1);
    check("clean_q", {31'd0, tb_q}, 32'd1);

    // Bounce: high 2 / low 1, ten times
    do_reset();
    npulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("bounce_pulses", npulses, 32'd0);
    check("bounce_level", {31'd0, level}, 32'd0);
    check("bounce_count", {24'd0, press_count}, 32'd0);

    // Release glitch while held
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    npulses = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("glitch_level", {31'd0, level}, 32'd1);
    check("glitch_pulses", npulses, 32'd0);
    check("glitch_count", {24'd0, press_count}, 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("glitch_release_level", {31'd0, level}, 32'd0);

    // Counter wrap
    do_reset();
    npulses = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    end
    check("wrap_pulses", npulses, 32'd256);
    check("wrap_count", {24'd0, press_count}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("wrap_count_257", {24'd0, press_count}, 32'd1);

    // Long hold past entry to HELD
    do_reset();
    npulses = 0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step(1'b0, 1'b1);
      if (pulse) seen = 1;
    end
    check("hold_press_seen", seen, 32'd1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    check("hold_pulses", npulses, exp_rep);
    check("hold_count", {24'd0, press_count}, exp_rep);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // Random runs with occasional reset, checked cycle by cycle against the model
    do_reset();
    for (int r = 0; r < 400; r++) begin
      logic b;
      int   len;
      logic rr;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      rr  = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < len; i++) step(rr && (i == 0), b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
